dm_cache: RTL and testbench

- Direct-mapped, write-back, write-allocate cache controller between the CPU load/store port and data_ram.
- Hits are served locally. Misses issue word-by-word transactions on data_ram's cs/we/addr/din/dout/ack handshake: dirty-victim writeback first, then line refill.
- CPU-side handshake mirrors the memory side (cs/we/stall/ack), so the CPU binds to either one.

---
 rtl/cache_pkg.sv | 38 +++
 rtl/dm_cache_if.sv | 14 +
 rtl/cache_line_array.sv | 54 +++++
 rtl/dm_cache.sv | 213 +++++++++++++++++++++
 tb/tb_dm_cache.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped cache: FSM states, geometry
// derivations and word-address field extraction helpers.
package cache_pkg;

  localparam int DEF_INDEX_WIDTH  = 2;
  localparam int DEF_OFFSET_WIDTH = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACKED  = 3'd1,
    S_WB     = 3'd2,
    S_WB_GAP = 3'd3,
    S_RF     = 3'd4,
    S_RF_GAP = 3'd5
  } state_t;

  function automatic int tag_width(input int iw, input int ow);
    return 32 - iw - ow;
  endfunction

  function automatic int words_per_line(input int ow);
    return 1 << ow;
  endfunction

  // Field helpers return full-width values; callers keep the low bits.
  function automatic logic [31:0] addr_offset(input logic [31:0] addr, input int ow);
    return addr & ((32'd1 << ow) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int iw, input int ow);
    return (addr >> ow) & ((32'd1 << iw) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int iw, input int ow);
    return addr >> (iw + ow);
  endfunction

endpackage

// File: rtl/dm_cache_if.sv
// Word-wide cs/we/stall/ack request bus. The same shape serves the CPU port
// (cache is the slave) and the memory port (cache is the master).
interface dm_cache_if;
  logic        cs;
  logic        we;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        stall;
  logic        ack;

  modport master (output cs, we, addr, din, input dout, stall, ack);
  modport slave  (input cs, we, addr, din, output dout, stall, ack);
endinterface

// File: rtl/cache_line_array.sv
// Line storage: valid/dirty bits (cleared on reset), tags and data words
// (not cleared). One combinational read port, one synchronous write port.
module cache_line_array #(
  parameter int INDEX_WIDTH  = 2,
  parameter int OFFSET_WIDTH = 2,
  parameter int TAG_WIDTH    = 28
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [INDEX_WIDTH-1:0]  rd_index,
  input  logic [OFFSET_WIDTH-1:0] rd_offset,
  output logic                    rd_valid,
  output logic                    rd_dirty,
  output logic [TAG_WIDTH-1:0]    rd_tag,
  output logic [31:0]             rd_word,
  input  logic                    word_we,
  input  logic                    meta_we,
  input  logic [INDEX_WIDTH-1:0]  wr_index,
  input  logic [OFFSET_WIDTH-1:0] wr_offset,
  input  logic [31:0]             wr_data,
  input  logic [TAG_WIDTH-1:0]    wr_tag,
  input  logic                    wr_valid,
  input  logic                    wr_dirty
);
  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int WORDS = 1 << OFFSET_WIDTH;

  logic [LINES-1:0]     valid_bits;
  logic [LINES-1:0]     dirty_bits;
  logic [TAG_WIDTH-1:0] tag_mem  [LINES];
  logic [31:0]          data_mem [LINES][WORDS];

  assign rd_valid = valid_bits[rd_index];
  assign rd_dirty = dirty_bits[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_word  = data_mem[rd_index][rd_offset];

  // Line state bits: cleared by reset, updated with the metadata write.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_bits <= '0;
      dirty_bits <= '0;
    end else if (meta_we) begin
      valid_bits[wr_index] <= wr_valid;
      dirty_bits[wr_index] <= wr_dirty;
    end
  end

  // Tag and data words: plain storage, contents survive reset.
  always_ff @(posedge clk) begin
    if (meta_we) tag_mem[wr_index] <= wr_tag;
    if (word_we) data_mem[wr_index][wr_offset] <= wr_data;
  end
endmodule

// File: rtl/dm_cache.sv
// Direct-mapped write-back/write-allocate cache controller. Hits complete in
// one cycle; misses write back a dirty victim word by word, then refill the
// line, then re-run the lookup (which now hits).
module dm_cache
  import cache_pkg::*;
#(
  parameter int INDEX_WIDTH  = DEF_INDEX_WIDTH,
  parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH
) (
  input logic        clk,
  input logic        rst,
  dm_cache_if.slave  cpu,
  dm_cache_if.master mem
);
  localparam int TAG_WIDTH      = tag_width(INDEX_WIDTH, OFFSET_WIDTH);
  localparam int WORDS_PER_LINE = words_per_line(OFFSET_WIDTH);

  state_t                  state;
  logic [OFFSET_WIDTH-1:0] cnt;
  logic [OFFSET_WIDTH-1:0] cnt_next;
  logic                    last_word;
  logic [INDEX_WIDTH-1:0]  req_index;
  logic [TAG_WIDTH-1:0]    req_tag;

  logic [31:0]             cpu_off_full, cpu_idx_full, cpu_tag_full;
  logic [OFFSET_WIDTH-1:0] cpu_offset;
  logic [INDEX_WIDTH-1:0]  cpu_index;
  logic [TAG_WIDTH-1:0]    cpu_tag;
  logic                    unused_bits;

  logic [INDEX_WIDTH-1:0]  rd_index;
  logic [OFFSET_WIDTH-1:0] rd_offset;
  logic                    rd_valid, rd_dirty, hit;
  logic [TAG_WIDTH-1:0]    rd_tag;
  logic [31:0]             rd_word;

  logic                    word_we, meta_we, wr_valid, wr_dirty;
  logic [INDEX_WIDTH-1:0]  wr_index;
  logic [OFFSET_WIDTH-1:0] wr_offset;
  logic [31:0]             wr_data;
  logic [TAG_WIDTH-1:0]    wr_tag;

  assign cpu_off_full = addr_offset(cpu.addr, OFFSET_WIDTH);
  assign cpu_idx_full = addr_index(cpu.addr, INDEX_WIDTH, OFFSET_WIDTH);
  assign cpu_tag_full = addr_tag(cpu.addr, INDEX_WIDTH, OFFSET_WIDTH);
  assign cpu_offset   = cpu_off_full[OFFSET_WIDTH-1:0];
  assign cpu_index    = cpu_idx_full[INDEX_WIDTH-1:0];
  assign cpu_tag      = cpu_tag_full[TAG_WIDTH-1:0];
  // mem.stall carries no information the ack handshake lacks.
  assign unused_bits  = ^{mem.stall, cpu_off_full[31:OFFSET_WIDTH],
                          cpu_idx_full[31:INDEX_WIDTH], cpu_tag_full[31:TAG_WIDTH]};

  assign cnt_next  = cnt + OFFSET_WIDTH'(1);
  assign last_word = (cnt == OFFSET_WIDTH'(WORDS_PER_LINE - 1));
  assign hit       = rd_valid && (rd_tag == cpu_tag);
  assign cpu.stall = cpu.cs & ~cpu.ack;

  cache_line_array #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .OFFSET_WIDTH(OFFSET_WIDTH),
    .TAG_WIDTH   (TAG_WIDTH)
  ) u_lines (
    .clk(clk), .rst(rst),
    .rd_index(rd_index), .rd_offset(rd_offset),
    .rd_valid(rd_valid), .rd_dirty(rd_dirty), .rd_tag(rd_tag), .rd_word(rd_word),
    .word_we(word_we), .meta_we(meta_we), .wr_index(wr_index), .wr_offset(wr_offset),
    .wr_data(wr_data), .wr_tag(wr_tag), .wr_valid(wr_valid), .wr_dirty(wr_dirty)
  );

  // Read port steering: CPU lookup in IDLE, victim word otherwise
  // (WB_GAP prefetches the next word so it launches with the request).
  always_comb begin
    rd_index  = req_index;
    rd_offset = cnt;
    case (state)
      S_IDLE: begin
        rd_index  = cpu_index;
        rd_offset = cpu_offset;
      end
      S_WB_GAP: rd_offset = cnt_next;
      default:  rd_offset = cnt;
    endcase
  end

  // Write port: store-hit merge, dirty clear after writeback, refill words.
  always_comb begin
    word_we   = 1'b0;
    meta_we   = 1'b0;
    wr_index  = req_index;
    wr_offset = cnt;
    wr_data   = mem.dout;
    wr_tag    = req_tag;
    wr_valid  = 1'b1;
    wr_dirty  = 1'b0;
    case (state)
      S_IDLE: begin
        if (cpu.cs && hit && cpu.we) begin
          word_we   = 1'b1;
          meta_we   = 1'b1;
          wr_index  = cpu_index;
          wr_offset = cpu_offset;
          wr_data   = cpu.din;
          wr_tag    = cpu_tag;
          wr_dirty  = 1'b1;
        end else begin
          word_we = 1'b0;
        end
      end
      S_WB: begin
        if (mem.cs && mem.ack && last_word) begin
          meta_we = 1'b1;
          wr_tag  = rd_tag;
        end else begin
          meta_we = 1'b0;
        end
      end
      S_RF: begin
        if (mem.cs && mem.ack) begin
          word_we = 1'b1;
          meta_we = last_word;
        end else begin
          word_we = 1'b0;
        end
      end
      default: word_we = 1'b0;
    endcase
  end

  // Control FSM with registered CPU and memory outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      req_index <= '0;
      req_tag   <= '0;
      cpu.ack   <= 1'b0;
      cpu.dout  <= 32'd0;
      mem.cs    <= 1'b0;
      mem.we    <= 1'b0;
      mem.addr  <= 32'd0;
      mem.din   <= 32'd0;
    end else begin
      cpu.ack  <= 1'b0;
      cpu.dout <= 32'd0;
      case (state)
        S_IDLE: begin
          if (cpu.cs) begin
            if (hit) begin
              cpu.ack  <= 1'b1;
              cpu.dout <= cpu.we ? 32'd0 : rd_word;
              state    <= S_ACKED;
            end else begin
              req_index <= cpu_index;
              req_tag   <= cpu_tag;
              cnt       <= '0;
              state     <= (rd_valid && rd_dirty) ? S_WB : S_RF;
            end
          end
        end
        S_ACKED: state <= S_IDLE;
        S_WB: begin
          if (!mem.cs) begin
            mem.cs   <= 1'b1;
            mem.we   <= 1'b1;
            mem.addr <= {rd_tag, req_index, cnt};
            mem.din  <= rd_word;
          end else if (mem.ack) begin
            mem.cs <= 1'b0;
            if (last_word) begin
              cnt   <= '0;
              state <= S_RF;
            end else begin
              state <= S_WB_GAP;
            end
          end
        end
        S_WB_GAP: begin
          cnt      <= cnt_next;
          mem.cs   <= 1'b1;
          mem.we   <= 1'b1;
          mem.addr <= {rd_tag, req_index, cnt_next};
          mem.din  <= rd_word;
          state    <= S_WB;
        end
        S_RF: begin
          if (!mem.cs) begin
            mem.cs   <= 1'b1;
            mem.we   <= 1'b0;
            mem.addr <= {req_tag, req_index, cnt};
            mem.din  <= 32'd0;
          end else if (mem.ack) begin
            mem.cs <= 1'b0;
            if (last_word) begin
              cnt   <= '0;
              state <= S_IDLE;
            end else begin
              state <= S_RF_GAP;
            end
          end
        end
        S_RF_GAP: begin
          cnt      <= cnt_next;
          mem.cs   <= 1'b1;
          mem.we   <= 1'b0;
          mem.addr <= {req_tag, req_index, cnt_next};
          mem.din  <= 32'd0;
          state    <= S_RF;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dm_cache.sv
// Directed bench for dm_cache against a small data_ram model
// (32 words, data[i] = i, 8-cycle response, one-cycle ack).
module tb_dm_cache;
  localparam int ADDR_WIDTH = 5;
  localparam int CLK_DELAY  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm_cache_if cpu_bus();
  dm_cache_if mem_bus();

  dm_cache #(.INDEX_WIDTH(2), .OFFSET_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .cpu(cpu_bus), .mem(mem_bus)
  );

  // data_ram model
  logic [31:0] ram [2**ADDR_WIDTH];
  logic        ram_init = 1'b0;
  int          mcnt;
  logic        mdone;
  assign mem_bus.stall = mem_bus.cs & ~mem_bus.ack;

  // Memory: count CLK_DELAY cycles, pulse ack, then wait for cs to drop.
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 2**ADDR_WIDTH; i++) ram[i] <= 32'(i);
      ram_init <= 1'b1;
    end
    if (rst) begin
      mem_bus.ack <= 1'b0;
      mcnt        <= 0;
      mdone       <= 1'b0;
    end else if (mdone) begin
      mem_bus.ack <= 1'b0;
      if (!mem_bus.cs) mdone <= 1'b0;
    end else if (mem_bus.cs) begin
      if (mcnt == CLK_DELAY - 1) begin
        mem_bus.ack <= 1'b1;
        mdone       <= 1'b1;
        mcnt        <= 0;
        if (mem_bus.we) ram[mem_bus.addr[ADDR_WIDTH-1:0]] <= mem_bus.din;
        else mem_bus.dout <= ram[mem_bus.addr[ADDR_WIDTH-1:0]];
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mcnt <= 0;
    end
  end

  int checks = 0;
  int errors = 0;

  logic [31:0] rd_log[$];
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  int          gap_err;
  int          req_cyc;
  logic [31:0] req_dout;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] exp_dout;
    int          exp_rd;
    logic [31:0] rd_base;
    int          exp_wr;
    logic [31:0] wr_base;
    int          exp_cyc;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] wexp[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Issue one CPU request, log memory traffic, return at the ack cycle.
  task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] din,
                         input logic drop, output logic ok);
    logic prev_cs;
    logic seen;
    int   low_run;
    rd_log.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
    gap_err = 0;
    req_cyc = 0;
    req_dout = 32'd0;
    ok = 1'b0;
    prev_cs = mem_bus.cs;
    seen = 1'b0;
    low_run = 0;
    cpu_bus.cs   = 1'b1;
    cpu_bus.we   = we;
    cpu_bus.addr = addr;
    cpu_bus.din  = din;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clk);
      req_cyc++;
      if (mem_bus.cs && mem_bus.ack) begin
        seen = 1'b1;
        if (mem_bus.we) begin
          wr_addr_log.push_back(mem_bus.addr);
          wr_data_log.push_back(mem_bus.din);
        end else begin
          rd_log.push_back(mem_bus.addr);
        end
      end
      if (mem_bus.cs && !prev_cs && seen && low_run != 1) gap_err++;
      low_run = mem_bus.cs ? 0 : low_run + 1;
      prev_cs = mem_bus.cs;
      if (cpu_bus.ack) begin
        ok = 1'b1;
        req_dout = cpu_bus.dout;
        if (drop) cpu_bus.cs = 1'b0;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: no cpu_ack for addr %0d, required within 2000 cycles", addr);
      cpu_bus.cs = 1'b0;
    end
  endtask

  initial begin
    logic ok;
    logic found;
    int   acks;

    rst = 1'b1;
    cpu_bus.cs = 1'b0; cpu_bus.we = 1'b0; cpu_bus.addr = 32'd0; cpu_bus.din = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_cpu_ack", {31'd0, cpu_bus.ack}, 32'd0);
    chk("rst_cpu_dout", cpu_bus.dout, 32'd0);
    chk("rst_cpu_stall", {31'd0, cpu_bus.stall}, 32'd0);
    chk("rst_mem_cs", {31'd0, mem_bus.cs}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_bus.we}, 32'd0);
    chk("rst_mem_addr", mem_bus.addr, 32'd0);
    chk("rst_mem_din", mem_bus.din, 32'd0);

    //          we    addr    din      dout     rd base    wr base    cyc
    vecs[0] = '{1'b0, 32'd5,  32'd0,   32'd5,   4, 32'd4,  0, 32'd0, 0};
    vecs[1] = '{1'b0, 32'd6,  32'd0,   32'd6,   0, 32'd0,  0, 32'd0, 1};
    vecs[2] = '{1'b1, 32'd6,  32'hAA,  32'd0,   0, 32'd0,  0, 32'd0, 1};
    vecs[3] = '{1'b0, 32'd6,  32'd0,   32'hAA,  0, 32'd0,  0, 32'd0, 1};
    vecs[4] = '{1'b0, 32'd22, 32'd0,   32'd22,  4, 32'd20, 4, 32'd4, 0};
    vecs[5] = '{1'b1, 32'd9,  32'h55,  32'd0,   4, 32'd8,  0, 32'd0, 0};
    vecs[6] = '{1'b0, 32'd9,  32'd0,   32'h55,  0, 32'd0,  0, 32'd0, 1};
    vecs[7] = '{1'b0, 32'd10, 32'd0,   32'd10,  0, 32'd0,  0, 32'd0, 1};
    wexp[0] = 32'd4; wexp[1] = 32'd5; wexp[2] = 32'hAA; wexp[3] = 32'd7;

    for (int i = 0; i < 8; i++) begin
      run_req(vecs[i].we, vecs[i].addr, vecs[i].din, 1'b1, ok);
      if (ok) begin
        if (!vecs[i].we) chk($sformatf("v%0d_dout", i), req_dout, vecs[i].exp_dout);
        chk($sformatf("v%0d_nrd", i), 32'(rd_log.size()), 32'(vecs[i].exp_rd));
        chk($sformatf("v%0d_nwr", i), 32'(wr_addr_log.size()), 32'(vecs[i].exp_wr));
        chk($sformatf("v%0d_gap", i), 32'(gap_err), 32'd0);
        if (vecs[i].exp_cyc != 0)
          chk($sformatf("v%0d_latency", i), 32'(req_cyc), 32'(vecs[i].exp_cyc));
        for (int k = 0; k < rd_log.size() && k < vecs[i].exp_rd; k++)
          chk($sformatf("v%0d_rd_addr%0d", i, k), rd_log[k], vecs[i].rd_base + 32'(k));
        for (int k = 0; k < wr_addr_log.size() && k < vecs[i].exp_wr; k++) begin
          chk($sformatf("v%0d_wr_addr%0d", i, k), wr_addr_log[k], vecs[i].wr_base + 32'(k));
          chk($sformatf("v%0d_wr_data%0d", i, k), wr_data_log[k], wexp[k]);
        end
      end
      @(negedge clk);
    end
    chk("ram6_after_wb", ram[6], 32'hAA);

    // Reset during the second refill word of load 13.
    cpu_bus.cs = 1'b1; cpu_bus.we = 1'b0; cpu_bus.addr = 32'd13;
    acks = 0;
    found = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(negedge clk);
      if (mem_bus.cs && mem_bus.ack) acks++;
      if (acks == 1 && mem_bus.cs && !mem_bus.ack) found = 1'b1;
    end
    if (found) begin
      chk("mid_rf_addr", mem_bus.addr, 32'd13);
      chk("mid_rf_stall", {31'd0, cpu_bus.stall}, 32'd1);
    end else begin
      checks++;
      errors++;
      $display("FAIL mid_rf_wait: second refill word not seen, required within 500 cycles");
    end
    rst = 1'b1;
    cpu_bus.cs = 1'b0;
    @(negedge clk);
    chk("rst_mid_mem_cs", {31'd0, mem_bus.cs}, 32'd0);
    chk("rst_mid_cpu_ack", {31'd0, cpu_bus.ack}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_req(1'b0, 32'd5, 32'd0, 1'b1, ok);
    if (ok) begin
      chk("post_rst_dout", req_dout, 32'd5);
      chk("post_rst_nrd", 32'(rd_log.size()), 32'd4);
      chk("post_rst_nwr", 32'(wr_addr_log.size()), 32'd0);
      if (rd_log.size() > 0) chk("post_rst_rd0", rd_log[0], 32'd4);
    end
    @(negedge clk);

    // Back-to-back loads with cpu_cs held high.
    run_req(1'b0, 32'd20, 32'd0, 1'b0, ok);
    if (ok) begin
      chk("b2b_dout20", req_dout, 32'd20);
      chk("b2b_nrd20", 32'(rd_log.size()), 32'd4);
      chk("b2b_gap20", 32'(gap_err), 32'd0);
    end
    cpu_bus.addr = 32'd21;
    @(negedge clk);
    chk("b2b_ack_low", {31'd0, cpu_bus.ack}, 32'd0);
    chk("b2b_dout_low", cpu_bus.dout, 32'd0);
    run_req(1'b0, 32'd21, 32'd0, 1'b1, ok);
    if (ok) begin
      chk("b2b_dout21", req_dout, 32'd21);
      chk("b2b_lat21", 32'(req_cyc), 32'd1);
      chk("b2b_nrd21", 32'(rd_log.size()), 32'd0);
    end
    @(negedge clk);
    chk("b2b_ack_end", {31'd0, cpu_bus.ack}, 32'd0);
    chk("b2b_mem_idle", {31'd0, mem_bus.cs}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
